// File: rtl/modsq_coeff_normalizer_pkg.sv
// ============================================================================
// Module : modsq_pkg
// Brief  : Shared constants and state encoding for the coefficient normalizer.
//          WORD_LEN   - weight of one coefficient in bits
//          BIT_LEN    - significant bits carried by each coefficient slot
//          CARRY_BITS - width of the inter-coefficient carry (bound is 2)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package modsq_pkg;

    localparam int WORD_LEN   = 16;
    localparam int BIT_LEN    = 17;
    localparam int CARRY_BITS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/modsq_coeff_normalizer_if.sv
// ============================================================================
// Module : modsq_coeff_normalizer_if
// Brief  : Handshake and data bus of the coefficient normalizer.
//          in_valid/in_ready/sq_out      - redundant coefficient bus in
//          out_valid/out_ready/result    - canonical result out
//          overflow, coef_err            - status reported with the result
//          master : producer/consumer side, slave : normalizer side
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface modsq_coeff_normalizer_if #(
    parameter int SQ_OUT_BITS = 2112,
    parameter int RES_BITS    = 1056
);
    logic                   in_valid;
    logic                   in_ready;
    logic [SQ_OUT_BITS-1:0] sq_out;
    logic                   out_valid;
    logic                   out_ready;
    logic [RES_BITS-1:0]    result;
    logic                   overflow;
    logic                   coef_err;

    modport master (
        output in_valid, sq_out, out_ready,
        input  in_ready, out_valid, result, overflow, coef_err
    );

    modport slave (
        input  in_valid, sq_out, out_ready,
        output in_ready, out_valid, result, overflow, coef_err
    );
endinterface

`default_nettype wire

// File: rtl/modsq_coeff_normalizer_slice.sv
// ============================================================================
// Module : modsq_norm_slice
// Brief  : Combinational carry chain across E coefficients.
//          coef_i  - E coefficients of BIT_LEN bits, coefficient 0 lowest
//          carry_i - carry from the previous group
//          word_o  - E canonical WORD_LEN-bit words
//          carry_o - carry out of the top coefficient
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module modsq_norm_slice #(
    parameter int E          = 6,
    parameter int WORD_LEN   = modsq_pkg::WORD_LEN,
    parameter int BIT_LEN    = modsq_pkg::BIT_LEN,
    parameter int CARRY_BITS = modsq_pkg::CARRY_BITS
) (
    input  logic [E*BIT_LEN-1:0]  coef_i,
    input  logic [CARRY_BITS-1:0] carry_i,
    output logic [E*WORD_LEN-1:0] word_o,
    output logic [CARRY_BITS-1:0] carry_o
);
    // c <= 2^17-1 and carry <= 2 keep every partial sum below 2^18.
    localparam int SUM_W = WORD_LEN + CARRY_BITS;

    logic [SUM_W-1:0]      sum;
    logic [CARRY_BITS-1:0] carry;

    always_comb begin
        word_o = '0;
        sum    = '0;
        carry  = carry_i;
        for (int i = 0; i < E; i++) begin
            sum   = SUM_W'(coef_i[i*BIT_LEN +: BIT_LEN]) + SUM_W'(carry);
            word_o[i*WORD_LEN +: WORD_LEN] = sum[WORD_LEN-1:0];
            carry = sum[SUM_W-1:WORD_LEN];
        end
        carry_o = carry;
    end
endmodule

`default_nettype wire

// File: rtl/modsq_coeff_normalizer.sv
// ============================================================================
// Module : modsq_coeff_normalizer
// Brief  : Ripples redundant-form squaring coefficients into a canonical
//          NUM_ELEMENTS*WORD_LEN-bit integer, ELEMS_PER_CYCLE coefficients
//          per cycle, with overflow flag and valid/ready handshake.
//          clk   - sole clock
//          reset - synchronous, active-high
//          norm  - slave side of modsq_coeff_normalizer_if
//          Optional macro MODSQ_NORM_CHECK_EN builds the padding-bit check
//          driving coef_err; without it coef_err is tied low.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MOD_LEN_DEF
`define MOD_LEN_DEF 1024
`endif

module modsq_coeff_normalizer #(
    parameter int MOD_LEN               = `MOD_LEN_DEF,
    parameter int WORD_LEN              = modsq_pkg::WORD_LEN,
    parameter int REDUNDANT_ELEMENTS    = 2,
    parameter int NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
    parameter int NUM_ELEMENTS          = REDUNDANT_ELEMENTS + NONREDUNDANT_ELEMENTS,
    parameter int ELEMS_PER_CYCLE       = 6,
    parameter int SQ_OUT_BITS           = NUM_ELEMENTS * WORD_LEN * 2,
    parameter int RES_BITS              = NUM_ELEMENTS * WORD_LEN
) (
    input  logic                      clk,
    input  logic                      reset,
    modsq_coeff_normalizer_if.slave   norm
);
    import modsq_pkg::*;

    localparam int E         = ELEMS_PER_CYCLE;
    localparam int NUM_STEPS = NUM_ELEMENTS / E;
    localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int SLOT_W    = 2 * WORD_LEN;
    localparam int PAD_W     = SLOT_W - BIT_LEN;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    generate
        if ((NUM_ELEMENTS % ELEMS_PER_CYCLE) != 0) begin : g_cfg_err
            $error("ELEMS_PER_CYCLE must divide NUM_ELEMENTS");
        end
    endgenerate

    state_t                state_q;
    logic [STEP_W-1:0]     step_q;
    logic [CARRY_BITS-1:0] carry_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  overflow_q;
    // Coefficients and result words are grouped per step so that the
    // slice input and result write-back are a plain array index.
    logic [E*BIT_LEN-1:0]  coef_q   [NUM_STEPS];
    logic [E*WORD_LEN-1:0] result_q [NUM_STEPS];

    logic [E*WORD_LEN-1:0] words_d;
    logic [CARRY_BITS-1:0] carry_d;

    modsq_norm_slice #(
        .E          (E),
        .WORD_LEN   (WORD_LEN),
        .BIT_LEN    (BIT_LEN),
        .CARRY_BITS (CARRY_BITS)
    ) u_slice (
        .coef_i  (coef_q[step_q]),
        .carry_i (carry_q),
        .word_o  (words_d),
        .carry_o (carry_d)
    );

`ifdef MODSQ_NORM_CHECK_EN
    logic coef_err_q;
    logic pad_err_d;

    always_comb begin
        pad_err_d = 1'b0;
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            pad_err_d = pad_err_d | (|norm.sq_out[j*SLOT_W+BIT_LEN +: PAD_W]);
        end
    end

    assign norm.coef_err = coef_err_q;
`else
    assign norm.coef_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            step_q      <= '0;
            carry_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            for (int s = 0; s < NUM_STEPS; s++) begin
                coef_q[s]   <= '0;
                result_q[s] <= '0;
            end
`ifdef MODSQ_NORM_CHECK_EN
            coef_err_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (norm.in_valid) begin
                        // Keep only the significant bits of each slot.
                        for (int s = 0; s < NUM_STEPS; s++) begin
                            for (int i = 0; i < E; i++) begin
                                coef_q[s][i*BIT_LEN +: BIT_LEN] <=
                                    norm.sq_out[(s*E+i)*SLOT_W +: BIT_LEN];
                            end
                        end
`ifdef MODSQ_NORM_CHECK_EN
                        coef_err_q <= pad_err_d;
`endif
                        step_q     <= '0;
                        carry_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    result_q[step_q] <= words_d;
                    carry_q          <= carry_d;
                    if (step_q == LAST_STEP) begin
                        overflow_q  <= (carry_d != '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                DONE: begin
                    if (norm.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        norm.result = '0;
        for (int s = 0; s < NUM_STEPS; s++) begin
            norm.result[s*E*WORD_LEN +: E*WORD_LEN] = result_q[s];
        end
    end

    assign norm.in_ready  = in_ready_q;
    assign norm.out_valid = out_valid_q;
    assign norm.overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_modsq_coeff_normalizer.sv
// ============================================================================
// Module : tb_modsq_coeff_normalizer
// Brief  : Self-checking bench for modsq_coeff_normalizer at default sizes.
//          Expected values come from a big-integer sum of c_j*2^(16j).
//          Honours MODSQ_NORM_CHECK_EN for the coef_err expectation.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modsq_coeff_normalizer;

    localparam int NUM_EL   = 66;
    localparam int E        = 6;
    localparam int SLOT     = 32;
    localparam int RES_BITS = NUM_EL * 16;
    localparam int SQ_BITS  = RES_BITS * 2;
    localparam int ACC_W    = RES_BITS + 4;
    localparam int LAT      = NUM_EL / E;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    modsq_coeff_normalizer_if #(.SQ_OUT_BITS(SQ_BITS), .RES_BITS(RES_BITS)) nif ();

    modsq_coeff_normalizer #(
        .MOD_LEN         (1024),
        .ELEMS_PER_CYCLE (E)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .norm  (nif)
    );

    int unsigned         coef [NUM_EL];
    logic [14:0]         pad  [NUM_EL];
    int                  n_assert = 0;
    int                  n_fail   = 0;
    logic [RES_BITS-1:0] exp_res;
    logic [RES_BITS-1:0] held_res;
    logic                exp_ov;
    logic                exp_err;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [RES_BITS-1:0] obs,
                           input logic [RES_BITS-1:0] exp);
        int k;
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            k = 0;
            for (int i = RES_BITS/32 - 1; i >= 0; i--) begin
                if (obs[i*32 +: 32] !== exp[i*32 +: 32]) k = i;
            end
            $error("FAIL %s: word32[%0d] observed %h expected %h",
                   tag, k, obs[k*32 +: 32], exp[k*32 +: 32]);
        end
    endtask

    // Reference: canonical value is the plain integer sum of weighted coefficients.
    task automatic compute_expected();
        logic [ACC_W-1:0] acc;
        logic [ACC_W-1:0] t;
        acc     = '0;
        exp_err = 1'b0;
        for (int j = 0; j < NUM_EL; j++) begin
            t       = '0;
            t[16:0] = coef[j][16:0];
            acc     = acc + (t << (16 * j));
`ifdef MODSQ_NORM_CHECK_EN
            if (pad[j] != 15'd0) exp_err = 1'b1;
`endif
        end
        exp_res = acc[RES_BITS-1:0];
        exp_ov  = |acc[ACC_W-1:RES_BITS];
    endtask

    task automatic fill(input int mode, input bit rand_pad);
        int unsigned pick;
        for (int j = 0; j < NUM_EL; j++) begin
            pad[j] = rand_pad ? 15'($urandom) : 15'd0;
            case (mode)
                0: coef[j] = 0;
                1: coef[j] = 32'h1FFFF;
                2: coef[j] = $urandom_range(0, 32'h1FFFF);
                default: begin
                    pick = $urandom_range(0, 4);
                    case (pick)
                        0: coef[j] = 0;
                        1: coef[j] = 32'hFFFF;
                        2: coef[j] = 32'h1FFFF;
                        3: coef[j] = 32'h10000;
                        default: coef[j] = $urandom_range(0, 32'h1FFFF);
                    endcase
                end
            endcase
        end
    endtask

    task automatic drive_bus();
        for (int j = 0; j < NUM_EL; j++) begin
            nif.sq_out[j*SLOT +: SLOT] = {pad[j], coef[j][16:0]};
        end
    endtask

    task automatic start_txn(input string tag);
        int n;
        n = 0;
        while (nif.in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk1({tag, "_in_ready_idle"}, nif.in_ready, 1'b1);
        drive_bus();
        nif.in_valid = 1'b1;
        @(posedge clk); #1;
        nif.in_valid = 1'b0;
        compute_expected();
    endtask

    // Capture edge T; out_valid becomes visible after edge T+LAT, i.e. in the
    // cycle closing at edge T+LAT+1.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (nif.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chkn({tag, "_latency"}, 64'(n), 64'(LAT));
        chk_res({tag, "_result"}, nif.result, exp_res);
        chk1({tag, "_overflow"}, nif.overflow, exp_ov);
        chk1({tag, "_coef_err"}, nif.coef_err, exp_err);
        chk1({tag, "_in_ready_done"}, nif.in_ready, 1'b0);
    endtask

    task automatic release_out(input string tag);
        nif.out_ready = 1'b1;
        @(posedge clk); #1;
        nif.out_ready = 1'b0;
        chk1({tag, "_out_valid_drop"}, nif.out_valid, 1'b0);
        chk1({tag, "_in_ready_back"}, nif.in_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        nif.in_valid  = 1'b0;
        nif.out_ready = 1'b0;
        nif.sq_out    = '0;
        reset         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_in_ready", nif.in_ready, 1'b1);
        chk1("rst_out_valid", nif.out_valid, 1'b0);
        chk_res("rst_result", nif.result, '0);
        chk1("rst_overflow", nif.overflow, 1'b0);
        chk1("rst_coef_err", nif.coef_err, 1'b0);
        reset = 1'b0;

        // All-zero coefficients.
        fill(0, 1'b0);
        start_txn("zero");
        wait_done("zero");
        chk_res("zero_const", nif.result, '0);
        release_out("zero");

        // Single maximal low coefficient.
        fill(0, 1'b0);
        coef[0] = 32'h1FFFF;
        start_txn("c0max");
        wait_done("c0max");
        chkn("c0max_low64", nif.result[63:0], 64'h0000_0000_0001_FFFF);
        chk1("c0max_ov_const", nif.overflow, 1'b0);
        release_out("c0max");

        // Every coefficient maximal: carries ripple to the top.
        fill(1, 1'b0);
        start_txn("allmax");
        wait_done("allmax");
        chk1("allmax_ov_const", nif.overflow, 1'b1);
        release_out("allmax");

        // Randomised buses, some with junk in the padding bits.
        for (int r = 0; r < 8; r++) begin
            fill((r % 2 == 0) ? 2 : 3, (r % 3 == 2));
            start_txn($sformatf("rand%0d", r));
            wait_done($sformatf("rand%0d", r));
            release_out($sformatf("rand%0d", r));
        end

        // Backpressure in DONE; a new bus offered meanwhile must be ignored.
        fill(3, 1'b0);
        start_txn("bp1");
        wait_done("bp1");
        held_res = nif.result;
        fill(2, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                drive_bus();
                nif.in_valid = 1'b1;
            end
            if (k == 3) nif.in_valid = 1'b0;
            @(posedge clk); #1;
            chk1($sformatf("bp_hold_valid%0d", k), nif.out_valid, 1'b1);
            chk1($sformatf("bp_hold_ready%0d", k), nif.in_ready, 1'b0);
            chk_res($sformatf("bp_hold_result%0d", k), nif.result, held_res);
        end
        nif.in_valid = 1'b0;
        release_out("bp1");
        chk_res("bp_after_release", nif.result, held_res);
        start_txn("bp2");
        wait_done("bp2");
        release_out("bp2");

        // Reset in the fourth RUN cycle discards partial work.
        fill(1, 1'b0);
        start_txn("midrst");
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk1("midrst_out_valid", nif.out_valid, 1'b0);
        chk1("midrst_in_ready", nif.in_ready, 1'b1);
        chk_res("midrst_result", nif.result, '0);
        chk1("midrst_overflow", nif.overflow, 1'b0);
        fill(0, 1'b0);
        coef[1] = 32'h10000;
        start_txn("c1");
        wait_done("c1");
        chkn("c1_low64", nif.result[63:0], 64'h0000_0001_0000_0000);
        release_out("c1");

        // Padding bit 20 in slot 3 with zero coefficients, then a clean bus.
        fill(0, 1'b0);
        pad[3] = 15'h0008;
        start_txn("pad");
        wait_done("pad");
`ifdef MODSQ_NORM_CHECK_EN
        chk1("pad_err_const", nif.coef_err, 1'b1);
`else
        chk1("pad_err_const", nif.coef_err, 1'b0);
`endif
        chk_res("pad_result_zero", nif.result, '0);
        release_out("pad");
        fill(0, 1'b0);
        start_txn("clean");
        wait_done("clean");
        chk1("clean_err_const", nif.coef_err, 1'b0);
        release_out("clean");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
